// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared types and constants for the PDP-8 instruction fetch unit.
// Address/data widths come from `ADDR_WIDTH / `DATA_WIDTH (12 bits unless
// the build overrides them).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

   localparam int ADDR_W = `ADDR_WIDTH;
   localparam int DATA_W = `DATA_WIDTH;

   // PC value loaded by reset.
   localparam logic [ADDR_W-1:0] IFU_START_ADDR = ADDR_W'(12'o0200);

   // Fetch FSM states (base, non-prefetch build).
   typedef enum logic [1:0] {
      IFU_IDLE    = 2'd0,
      IFU_FETCH   = 2'd1,
      IFU_WAIT    = 2'd2,
      IFU_DELIVER = 2'd3
   } ifu_state_t;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
   } ifu_entry_t;

   // PC increment: plain modulo-2^ADDR_W wrap, no field logic.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/pdp8_ifu_fifo.sv
// pdp8_ifu_fifo: small prefetch FIFO holding {pc,data} entries between the
// memory port and decode. Flush empties it in one cycle; a push and a pop in
// the same cycle are allowed even when full.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_ifu_fifo
   import pdp8_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  ifu_entry_t       push_entry,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output ifu_entry_t       head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   ifu_entry_t       mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;
   logic [PTR_W-1:0] wr_ptr_inc_s;
   logic [PTR_W-1:0] rd_ptr_inc_s;

   // Qualify push/pop and compute wrapped pointer increments.
   always_comb begin
      do_pop_s  = pop & (count_r != CNT_W'(0));
      do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
      if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
         wr_ptr_inc_s = PTR_W'(0);
      end else begin
         wr_ptr_inc_s = wr_ptr_r + PTR_W'(1);
      end
      if (rd_ptr_r == PTR_W'(DEPTH - 1)) begin
         rd_ptr_inc_s = PTR_W'(0);
      end else begin
         rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
      end
   end

   // Storage, pointers and occupancy; flush dominates push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (flush) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
            wr_ptr_r        <= wr_ptr_inc_s;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_inc_s;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == CNT_W'(DEPTH));
   assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/pdp8_instr_fetch.sv
// pdp8_instr_fetch: PDP-8 instruction fetch stage. Owns the PC, issues
// single-word reads (data returns the cycle after the request) and hands
// {pc,data} to decode over valid/ready. Redirect and halt come from execute.
// Build option IFU_PREFETCH_EN: replaces the 3-cycle FSM with a FIFO_DEPTH
// entry prefetch FIFO (pdp8_ifu_fifo) for up to one instruction per cycle.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp8_instr_fetch
   import pdp8_pkg::*;
#(
   parameter logic [ADDR_W-1:0] START_ADDR = IFU_START_ADDR
`ifdef IFU_PREFETCH_EN
   ,parameter int FIFO_DEPTH = 2
`endif
)(
   input  logic              clk,
   input  logic              reset_n,
   output logic              ifu_rd_req,
   output logic [ADDR_W-1:0] ifu_rd_addr,
   input  logic [DATA_W-1:0] ifu_rd_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              halt,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc
);

`ifdef IFU_PREFETCH_EN

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] inflight_pc_r;
   logic              inflight_r;
   logic              run_r;
   logic              req_s;
   logic              push_s;
   logic              pop_s;
   logic              space_s;
   logic              full_s;
   logic              empty_s;
   logic [CNT_W-1:0]  occ_s;
   ifu_entry_t        push_entry_s;
   ifu_entry_t        head_s;

   // Request whenever the FIFO can absorb the response; a pop this cycle
   // frees a slot so that ready held high sustains one fetch per cycle.
   always_comb begin
      pop_s   = ~empty_s & instr_ready;
      space_s = ({1'b0, occ_s} + (CNT_W + 1)'(inflight_r)) <
                ((CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop_s));
      req_s   = run_r & ~halt & ~redirect_valid & space_s;
      push_s  = inflight_r & ~redirect_valid;
      push_entry_s.pc   = inflight_pc_r;
      push_entry_s.data = ifu_rd_data;
   end

   // PC and in-flight tracking; redirect drops the outstanding response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r          <= START_ADDR;
         inflight_pc_r <= '0;
         inflight_r    <= 1'b0;
         run_r         <= 1'b0;
      end else begin
         run_r      <= 1'b1;
         inflight_r <= req_s;
         if (req_s) begin
            inflight_pc_r <= pc_r;
         end
         if (redirect_valid) begin
            pc_r <= redirect_addr;
         end else if (req_s) begin
            pc_r <= pc_inc(pc_r);
         end
      end
   end

   pdp8_ifu_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .flush      (redirect_valid),
      .full       (full_s),
      .empty      (empty_s),
      .count      (occ_s),
      .head       (head_s)
   );

   assign ifu_rd_req  = req_s;
   assign ifu_rd_addr = pc_r;
   assign instr_valid = ~empty_s;
   assign instr_data  = head_s.data;
   assign instr_pc    = head_s.pc;

`else

   ifu_state_t        state_r;
   ifu_state_t        state_n;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_n;
   logic [ADDR_W-1:0] instr_pc_r;
   logic [DATA_W-1:0] instr_data_r;
   logic              req_r;
   logic              req_n;
   logic              valid_r;
   logic              valid_n;
   logic              capture_s;

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IFU_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic; redirect overrides every state.
   always_comb begin
      state_n = state_r;
      if (redirect_valid) begin
         state_n = halt ? IFU_IDLE : IFU_FETCH;
      end else begin
         case (state_r)
            IFU_IDLE: begin
               if (!halt) begin
                  state_n = IFU_FETCH;
               end else begin
                  state_n = IFU_IDLE;
               end
            end
            IFU_FETCH:   state_n = IFU_WAIT;
            IFU_WAIT:    state_n = IFU_DELIVER;
            IFU_DELIVER: begin
               if (instr_ready) begin
                  state_n = halt ? IFU_IDLE : IFU_FETCH;
               end else begin
                  state_n = IFU_DELIVER;
               end
            end
            default:     state_n = IFU_IDLE;
         endcase
      end
   end

   // Output/datapath decode: next PC, capture strobe, next valid and req.
   always_comb begin
      pc_n      = pc_r;
      capture_s = 1'b0;
      valid_n   = 1'b0;
      if (redirect_valid) begin
         pc_n    = redirect_addr;
         valid_n = 1'b0;
      end else begin
         case (state_r)
            IFU_WAIT: begin
               capture_s = 1'b1;
               pc_n      = pc_inc(pc_r);
               valid_n   = 1'b1;
            end
            IFU_DELIVER: begin
               if (instr_ready) begin
                  valid_n = 1'b0;
               end else begin
                  valid_n = 1'b1;
               end
            end
            default: valid_n = 1'b0;
         endcase
      end
      req_n = (state_n == IFU_FETCH);
   end

   // Registered outputs and PC; the read response is sampled only in WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r         <= START_ADDR;
         req_r        <= 1'b0;
         valid_r      <= 1'b0;
         instr_data_r <= '0;
         instr_pc_r   <= '0;
      end else begin
         pc_r    <= pc_n;
         req_r   <= req_n;
         valid_r <= valid_n;
         if (capture_s) begin
            instr_data_r <= ifu_rd_data;
            instr_pc_r   <= pc_r;
         end
      end
   end

   assign ifu_rd_req  = req_r;
   assign ifu_rd_addr = pc_r;
   assign instr_valid = valid_r;
   assign instr_data  = instr_data_r;
   assign instr_pc    = instr_pc_r;

`endif

endmodule

// File: tb/tb_pdp8_instr_fetch.sv
// Directed testbench for pdp8_instr_fetch (base build). Memory returns
// addr + 'o7000 the cycle after a request and 'o5555 otherwise.

module tb_pdp8_instr_fetch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ifu_rd_req;
   logic [11:0] ifu_rd_addr;
   logic [11:0] ifu_rd_data = 12'o5555;
   logic        redirect_valid;
   logic [11:0] redirect_addr;
   logic        halt;
   logic        instr_valid;
   logic        instr_ready;
   logic [11:0] instr_data;
   logic [11:0] instr_pc;

   int errors = 0;
   int checks = 0;

   // Logs of requests and deliveries, written only by the monitor below.
   logic [11:0] req_log  [1024];
   logic [11:0] del_pc   [1024];
   logic [11:0] del_data [1024];
   int          del_cyc  [1024];
   int          req_n = 0;
   int          del_n = 0;
   int          cyc   = 0;
   int          req_base = 0;
   int          del_base = 0;

   pdp8_instr_fetch dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ifu_rd_req     (ifu_rd_req),
      .ifu_rd_addr    (ifu_rd_addr),
      .ifu_rd_data    (ifu_rd_data),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
   );

   always #5 clk = ~clk;

   // Memory model and request/delivery monitor.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      ifu_rd_data <= ifu_rd_req ? (ifu_rd_addr + 12'o7000) : 12'o5555;
      if (ifu_rd_req && req_n < 1024) begin
         req_log[req_n] <= ifu_rd_addr;
         req_n          <= req_n + 1;
      end
      if (instr_valid && instr_ready && del_n < 1024) begin
         del_pc[del_n]   <= instr_pc;
         del_data[del_n] <= instr_data;
         del_cyc[del_n]  <= cyc;
         del_n           <= del_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
      end
   endtask

   task automatic mark();
      req_base = req_n;
      del_base = del_n;
   endtask

   task automatic wait_del(input int n, input string tag);
      int b = 0;
      while ((del_n - del_base) < n && b < 40) begin
         @(negedge clk);
         b++;
      end
      check(tag, 32'((del_n - del_base) >= n), 32'd1);
   endtask

   task automatic wait_req(input int n, input string tag);
      int b = 0;
      while ((req_n - req_base) < n && b < 40) begin
         @(negedge clk);
         b++;
      end
      check(tag, 32'((req_n - req_base) >= n), 32'd1);
   endtask

   task automatic wait_req_high(input string tag);
      int b = 0;
      while (!ifu_rd_req && b < 40) begin
         @(negedge clk);
         b++;
      end
      check(tag, 32'(ifu_rd_req), 32'd1);
   endtask

   task automatic do_redirect(input logic [11:0] a, input logic rdy);
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_addr  = a;
      instr_ready    = rdy;
      @(negedge clk);
      redirect_valid = 1'b0;
      mark();
   endtask

   initial begin
      reset_n        = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 12'o0000;
      halt           = 1'b0;
      instr_ready    = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req",   32'(ifu_rd_req),  32'd0);
      check("rst_addr",  32'(ifu_rd_addr), 32'o0200);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_data",  32'(instr_data),  32'd0);
      check("rst_pc",    32'(instr_pc),    32'd0);
      reset_n = 1'b1;
      mark();

      // Basic fetch with ready high
      wait_del(2, "basic_timeout");
      check("basic_req0",  32'(req_log[req_base]),     32'o0200);
      check("basic_pc0",   32'(del_pc[del_base]),      32'o0200);
      check("basic_data0", 32'(del_data[del_base]),    32'o7200);
      check("basic_req1",  32'(req_log[req_base + 1]), 32'o0201);
      check("basic_pc1",   32'(del_pc[del_base + 1]),  32'o0201);
      check("basic_data1", 32'(del_data[del_base + 1]), 32'o7201);
      check("basic_rate",  32'(del_cyc[del_base + 1] - del_cyc[del_base]), 32'd3);

      // Backpressure on pc 'o0200
      do_redirect(12'o0200, 1'b0);
      begin
         int b = 0;
         while (!instr_valid && b < 40) begin
            @(negedge clk);
            b++;
         end
      end
      check("bp_valid", 32'(instr_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(instr_valid), 32'd1);
         check("bp_hold_pc",    32'(instr_pc),    32'o0200);
         check("bp_hold_data",  32'(instr_data),  32'o7200);
      end
      check("bp_no_req", 32'(req_n - req_base), 32'd1);
      instr_ready = 1'b1;
      wait_del(2, "bp_timeout");
      check("bp_pc0", 32'(del_pc[del_base]),     32'o0200);
      check("bp_pc1", 32'(del_pc[del_base + 1]), 32'o0201);

      // PC wrap
      do_redirect(12'o7777, 1'b1);
      wait_del(2, "wrap_timeout");
      check("wrap_pc0",   32'(del_pc[del_base]),       32'o7777);
      check("wrap_data0", 32'(del_data[del_base]),     32'o6777);
      check("wrap_pc1",   32'(del_pc[del_base + 1]),   32'o0000);
      check("wrap_data1", 32'(del_data[del_base + 1]), 32'o7000);

      // Redirect during WAIT
      do_redirect(12'o0300, 1'b1);
      wait_req_high("rdw_fetch");
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_addr  = 12'o0400;
      @(negedge clk);
      redirect_valid = 1'b0;
      mark();
      wait_del(1, "rdw_timeout");
      check("rdw_req",  32'(req_log[req_base]),  32'o0400);
      check("rdw_pc",   32'(del_pc[del_base]),   32'o0400);
      check("rdw_data", 32'(del_data[del_base]), 32'o7400);

      // Halt raised in FETCH
      do_redirect(12'o0500, 1'b1);
      wait_req_high("halt_fetch");
      mark();
      halt = 1'b1;
      repeat (12) @(negedge clk);
      check("halt_ndel",  32'(del_n - del_base),  32'd1);
      check("halt_pc",    32'(del_pc[del_base]),  32'o0500);
      check("halt_nreq",  32'(req_n - req_base),  32'd1);
      check("halt_valid", 32'(instr_valid),       32'd0);
      halt = 1'b0;
      wait_req(2, "halt_resume_timeout");
      check("halt_resume_addr", 32'(req_log[req_base + 1]), 32'o0501);

      // Asynchronous reset in WAIT
      do_redirect(12'o0600, 1'b1);
      wait_req_high("arst_fetch");
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_req",   32'(ifu_rd_req),  32'd0);
      check("arst_addr",  32'(ifu_rd_addr), 32'o0200);
      check("arst_valid", 32'(instr_valid), 32'd0);
      check("arst_data",  32'(instr_data),  32'd0);
      check("arst_pc",    32'(instr_pc),    32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mark();
      wait_req(1, "arst_req_timeout");
      check("arst_first_req", 32'(req_log[req_base]), 32'o0200);
      wait_del(1, "arst_del_timeout");
      check("arst_first_pc",   32'(del_pc[del_base]),   32'o0200);
      check("arst_first_data", 32'(del_data[del_base]), 32'o7200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
